wm_cycle_sequencer: RTL

//  Parametrised wash-cycle controller for the Washing_Machine top, replacing the fixed sequence.

---
 rtl/wm_cycle_sequencer.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wm_cycle_sequencer.sv
// Wash-cycle controller: fill/wash/drain, N rinses, spin, with pause,
// abort-through-drain, per-phase timeouts and a vibration filter.
module wm_cycle_sequencer #(
  parameter logic [9:0] FILL_TARGET   = 10'd600,
  parameter logic [9:0] DRAIN_EMPTY   = 10'd20,
  parameter int         FILL_TIMEOUT  = 50,
  parameter int         DRAIN_TIMEOUT = 40,
  parameter int         WASH_TICKS    = 100,
  parameter int         RINSE_TICKS   = 60,
  parameter int         SPIN_TICKS    = 80,
  parameter int         MAX_RINSES    = 3,
  parameter int         VIB_LIMIT     = 4,
  parameter int         TIMER_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       continue_signal,
  input  logic       door_locked,
  input  logic [2:0] rinse_count,
  input  logic [9:0] water_level_sensor,
  input  logic       vibration_sensor,
  output logic       door_lock,
  output logic       water_valve,
  output logic       drain_pump,
  output logic [3:0] drum_motor,
  output logic       cycle_complete_led,
  output logic       water_flow_error_led,
  output logic       drainage_error_led,
  output logic       vibration_error_led,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_RINSE  = 4'd3,
    S_DRAIN  = 4'd4,
    S_SPIN   = 4'd5,
    S_PAUSED = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  localparam logic [TIMER_W-1:0] FILL_END  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DRAIN_END = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] WASH_END  = TIMER_W'(WASH_TICKS - 1);
  localparam logic [TIMER_W-1:0] RINSE_END = TIMER_W'(RINSE_TICKS - 1);
  localparam logic [TIMER_W-1:0] SPIN_END  = TIMER_W'(SPIN_TICKS - 1);
  localparam logic [2:0]         RINSE_MAX = 3'(MAX_RINSES);
  localparam logic [7:0]         VIB_END   = 8'(VIB_LIMIT - 1);

  state_t             state, state_n;
  state_t             ret_state, ret_state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [2:0]         rinses, rinses_n;
  logic               washed, washed_n;
  logic               abort, abort_n;
  logic [7:0]         vib_cnt, vib_cnt_n;
  logic               flow_err, flow_err_n;
  logic               drain_err, drain_err_n;
  logic               vib_err, vib_err_n;

  logic       go;
  logic       fill_ok;
  logic       drain_ok;
  logic [2:0] rinse_req;

  assign go        = start && door_locked;
  assign fill_ok   = water_level_sensor >= FILL_TARGET;
  assign drain_ok  = water_level_sensor <= DRAIN_EMPTY;
  assign rinse_req = (rinse_count > RINSE_MAX) ? RINSE_MAX : rinse_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      timer     <= '0;
      rinses    <= '0;
      washed    <= 1'b0;
      abort     <= 1'b0;
      vib_cnt   <= '0;
      flow_err  <= 1'b0;
      drain_err <= 1'b0;
      vib_err   <= 1'b0;
    end else begin
      state     <= state_n;
      ret_state <= ret_state_n;
      timer     <= timer_n;
      rinses    <= rinses_n;
      washed    <= washed_n;
      abort     <= abort_n;
      vib_cnt   <= vib_cnt_n;
      flow_err  <= flow_err_n;
      drain_err <= drain_err_n;
      vib_err   <= vib_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    ret_state_n = ret_state;
    timer_n     = timer + TIMER_W'(1);
    rinses_n    = rinses;
    washed_n    = washed;
    abort_n     = abort;
    vib_cnt_n   = '0;
    flow_err_n  = flow_err;
    drain_err_n = drain_err;
    vib_err_n   = vib_err;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (go) begin
          state_n  = S_FILL;
          rinses_n = rinse_req;
          washed_n = 1'b0;
          abort_n  = 1'b0;
        end
      end
      S_FILL: begin
        if (stop) begin
          state_n = S_DRAIN;
          abort_n = 1'b1;
          timer_n = '0;
        end else if (fill_ok) begin
          state_n = washed ? S_RINSE : S_WASH;
          timer_n = '0;
        end else if (timer == FILL_END) begin
          state_n    = S_ERROR;
          flow_err_n = 1'b1;
          timer_n    = '0;
        end else if (pause) begin
          state_n     = S_PAUSED;
          ret_state_n = S_FILL;
          timer_n     = timer;
        end
      end
      S_WASH: begin
        if (stop) begin
          state_n = S_DRAIN;
          abort_n = 1'b1;
          timer_n = '0;
        end else if (pause) begin
          state_n     = S_PAUSED;
          ret_state_n = S_WASH;
          timer_n     = timer;
        end else if (timer == WASH_END) begin
          state_n  = S_DRAIN;
          washed_n = 1'b1;
          timer_n  = '0;
        end
      end
      S_RINSE: begin
        if (stop) begin
          state_n = S_DRAIN;
          abort_n = 1'b1;
          timer_n = '0;
        end else if (pause) begin
          state_n     = S_PAUSED;
          ret_state_n = S_RINSE;
          timer_n     = timer;
        end else if (timer == RINSE_END) begin
          state_n  = S_DRAIN;
          rinses_n = rinses - 3'd1;
          timer_n  = '0;
        end
      end
      S_DRAIN: begin
        // stop here only marks the cycle aborted; draining carries on
        if (stop) abort_n = 1'b1;
        if (drain_ok) begin
          timer_n = '0;
          if (abort || stop) state_n = S_IDLE;
          else if (rinses != 3'd0) state_n = S_FILL;
          else state_n = S_SPIN;
        end else if (timer == DRAIN_END) begin
          state_n     = S_ERROR;
          drain_err_n = 1'b1;
          timer_n     = '0;
        end else if (pause) begin
          state_n     = S_PAUSED;
          ret_state_n = S_DRAIN;
          timer_n     = timer;
        end
      end
      S_SPIN: begin
        if (stop) begin
          state_n = S_DRAIN;
          abort_n = 1'b1;
          timer_n = '0;
        end else if (vibration_sensor && vib_cnt == VIB_END) begin
          state_n   = S_ERROR;
          vib_err_n = 1'b1;
          timer_n   = '0;
        end else if (pause) begin
          state_n     = S_PAUSED;
          ret_state_n = S_SPIN;
          timer_n     = timer;
        end else if (timer == SPIN_END) begin
          state_n = S_DONE;
          timer_n = '0;
        end else begin
          vib_cnt_n = vibration_sensor ? vib_cnt + 8'd1 : 8'd0;
        end
      end
      S_PAUSED: begin
        timer_n = timer;
        if (stop) begin
          state_n = S_DRAIN;
          abort_n = 1'b1;
          timer_n = '0;
        end else if (continue_signal) begin
          state_n = ret_state;
        end
      end
      S_DONE: begin
        timer_n = '0;
        if (!door_locked) begin
          state_n = S_IDLE;
        end else if (start) begin
          state_n  = S_FILL;
          rinses_n = rinse_req;
          washed_n = 1'b0;
          abort_n  = 1'b0;
        end
      end
      S_ERROR: begin
        timer_n = '0;
        if (stop) begin
          state_n     = S_IDLE;
          flow_err_n  = 1'b0;
          drain_err_n = 1'b0;
          vib_err_n   = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_comb begin
    door_lock          = 1'b1;
    water_valve        = 1'b0;
    drain_pump         = 1'b0;
    drum_motor         = 4'b0000;
    cycle_complete_led = 1'b0;
    unique case (1'b1)
      (state == S_IDLE):  door_lock = 1'b0;
      (state == S_FILL):  water_valve = 1'b1;
      (state == S_WASH):  drum_motor = 4'b0001;
      (state == S_RINSE): drum_motor = 4'b0010;
      (state == S_DRAIN): drain_pump = 1'b1;
      (state == S_SPIN): begin
        drain_pump = 1'b1;
        drum_motor = 4'b1000;
      end
      (state == S_DONE): begin
        door_lock          = 1'b0;
        cycle_complete_led = 1'b1;
      end
      default: ;
    endcase
  end

  assign water_flow_error_led = flow_err;
  assign drainage_error_led   = drain_err;
  assign vibration_error_led  = vib_err;
  assign state_dbg            = state;

endmodule
